// File: rtl/systolic_mac_pe.sv
// Output-stationary signed MAC processing element for a 2-D systolic array, with drain shift chain.
// Latency: operand forwarding 1 cycle; accumulator/result updates 1 cycle after a firing beat.
// Backpressure: none; operands are consumed only when both valids are high, and drain/clear pre-empt accumulation.
module systolic_mac_pe #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int SATURATE   = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic                  a_vld_in,
    input  logic                  a_last_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    input  logic                  b_vld_in,
    output logic [DATA_WIDTH-1:0] a_out,
    output logic                  a_vld_out,
    output logic                  a_last_out,
    output logic [DATA_WIDTH-1:0] b_out,
    output logic                  b_vld_out,
    input  logic                  clear_in,
    input  logic                  drain_en,
    input  logic [ACC_WIDTH-1:0]  drain_in,
    output logic [ACC_WIDTH-1:0]  drain_out,
    output logic                  result_valid,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  term_cnt,
    output logic                  sat_flag,
    output logic                  err_mismatch
);

    localparam int PROD_WIDTH = 2 * DATA_WIDTH;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    // Most positive / most negative accumulator values used when clamping.
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic [1:0]                   state;
    logic [ACC_WIDTH-1:0]         acc;

    logic signed [PROD_WIDTH-1:0] a_ext;
    logic signed [PROD_WIDTH-1:0] b_ext;
    logic signed [PROD_WIDTH-1:0] prod_full;
    logic [ACC_WIDTH-1:0]         prod_ext;
    logic [ACC_WIDTH-1:0]         sum_raw;
    logic [ACC_WIDTH-1:0]         sum_clamped;
    logic [ACC_WIDTH-1:0]         sum_sel;
    logic                         sum_ovf;
    logic [CNT_WIDTH-1:0]         cnt_inc;
    logic                         fire;
    logic                         mismatch;

    // A beat only counts when both operands are present and no drain/clear owns the cycle.
    assign fire     = a_vld_in & b_vld_in & ~drain_en & ~clear_in;
    // Drain/clear exclusion is handled by the priority chain in the state block.
    assign mismatch = a_vld_in ^ b_vld_in;

    // Operands widened before the multiply so the product is exact at 2*DATA_WIDTH bits.
    assign a_ext     = PROD_WIDTH'($signed(a_in));
    assign b_ext     = PROD_WIDTH'($signed(b_in));
    assign prod_full = a_ext * b_ext;
    // Sign-extend the product into the accumulator domain; ACC_WIDTH >= PROD_WIDTH.
    assign prod_ext  = ACC_WIDTH'(prod_full);

    assign sum_raw = acc + prod_ext;
    // Two's-complement overflow: operands agree in sign but the result does not.
    assign sum_ovf = (acc[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                     (sum_raw[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
    // On overflow the direction is given by the (common) operand sign.
    assign sum_clamped = sum_ovf ? (acc[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX) : sum_raw;
    assign sum_sel     = (SATURATE != 0) ? sum_clamped : sum_raw;

    // Term counter sticks at all-ones rather than wrapping back to a misleading small count.
    assign cnt_inc = (&term_cnt) ? term_cnt : term_cnt + CNT_WIDTH'(1);

    // Systolic operand forwarding: always one register stage, regardless of PE state.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_out      <= '0;
            a_vld_out  <= 1'b0;
            a_last_out <= 1'b0;
            b_out      <= '0;
            b_vld_out  <= 1'b0;
        end else begin
            a_out      <= a_in;
            a_vld_out  <= a_vld_in;
            a_last_out <= a_last_in;
            b_out      <= b_in;
            b_vld_out  <= b_vld_in;
        end
    end

    // Accumulator, term counter, flags and FSM: reset > clear > drain > fire > mismatch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            acc          <= '0;
            term_cnt     <= '0;
            sat_flag     <= 1'b0;
            err_mismatch <= 1'b0;
        end else if (clear_in) begin
            // Discards any partial sum, including one mid-accumulation.
            state        <= S_IDLE;
            acc          <= '0;
            term_cnt     <= '0;
            sat_flag     <= 1'b0;
            err_mismatch <= 1'b0;
        end else if (drain_en) begin
            // Row-wide shift: take the west neighbour's value; counter and flags keep describing the last product.
            state <= S_DRAIN;
            acc   <= drain_in;
        end else if (fire) begin
            if (state == S_ACCUM) begin
                acc      <= sum_sel;
                term_cnt <= cnt_inc;
                if (sum_ovf) begin
                    sat_flag <= 1'b1;
                end
            end else begin
                // First term of a new dot product cannot overflow since ACC_WIDTH >= 2*DATA_WIDTH.
                acc      <= prod_ext;
                term_cnt <= CNT_WIDTH'(1);
                sat_flag <= 1'b0;
            end
            state <= a_last_in ? S_DONE : S_ACCUM;
        end else if (mismatch) begin
            // Half a beat arrived: flag it, but leave accumulation and state untouched.
            err_mismatch <= 1'b1;
        end
    end

    assign drain_out    = acc;
    assign result_valid = (state == S_DONE);
    assign busy         = (state == S_ACCUM);

endmodule
